// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared constants and types for the multicycle control unit
//
// Purpose: opcode values, FSM state encoding, alu_op codes, alu_src_b and
// pc_source select codes, and the packed bundle of datapath control lines.
// The ALU control stage imports the same alu_op codes from here.
// Ports: none (package).

package cpu_ctrl_pkg;

  // Instruction opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU operation class handed to the ALU control stage
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_known_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  // States whose exit always retires the instruction (MEMWRITE retires only
  // on the cycle memory accepts the write, so it is handled separately).
  function automatic logic retires_on_exit(input state_t s);
    return (s == S_MEMWB) || (s == S_ALUWB) || (s == S_ADDIWB) ||
           (s == S_BRANCH) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// rtl/multicycle_control_decode.sv - combinational state-to-datapath control decode
//
// Purpose: Moore decode of the current FSM state into every datapath strobe
// and mux select. Only FETCH looks at mem_ready, so the instruction register
// and PC update exactly on the cycle the instruction word arrives.
// Ports:
//   state_i      current FSM state
//   mem_ready_i  memory completed the current access this cycle
//   ctrl_o       packed control bundle (unlisted fields are 0)

module multicycle_control_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_RTYPE;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle datapath main control FSM
//
// Purpose: sequences each instruction through fetch, decode, execute, memory
// and writeback, holding in memory states until mem_ready, and drives all
// datapath controls. Holds the state register, next-state logic, the opcode
// latched in DECODE, and the illegal_op / instr_done pulse registers.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   opcode_i[5:0]           instruction bits [31:26], sampled in DECODE
//   mem_ready_i             memory handshake for fetch / load / store
//   pc_write_o .. reg_write_o   datapath strobes
//   i_or_d_o .. alu_src_a_o     datapath mux selects
//   alu_src_b_o, pc_source_o    2-bit mux selects
//   alu_op_o                ALU operation class for the ALU control stage
//   illegal_op_o            one-cycle pulse after an unknown opcode decodes
//   instr_done_o            one-cycle pulse after an instruction retires
//   state_o[3:0]            current state, for debug

module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       i_or_d_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_op_o,
  output logic       instr_done_o,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic [5:0] opcode_q;
  logic       illegal_q, illegal_d;
  logic       done_q, done_d;
  ctrl_t      dec_ctrl;
  ctrl_t      ctrl;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only LW and SW reach MEMADR, so the latched opcode picks between them
      S_MEMADR:   state_d = (opcode_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready_i ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready_i ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEX:   state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  assign illegal_d = (state_q == S_DECODE) && !is_known_opcode(opcode_i);
  assign done_d    = retires_on_exit(state_q) ||
                     ((state_q == S_MEMWRITE) && mem_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (state_q == S_DECODE) begin
        opcode_q <= opcode_i;
      end
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  multicycle_control_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (dec_ctrl)
  );

  // The state register resets to FETCH, whose decode asserts mem_read; the
  // outputs are masked so nothing reaches the datapath while reset is held.
  assign ctrl = rst_i ? '0 : dec_ctrl;

  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign ir_write_o      = ctrl.ir_write;
  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write;
  assign reg_write_o     = ctrl.reg_write;
  assign i_or_d_o        = ctrl.i_or_d;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign reg_dst_o       = ctrl.reg_dst;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign pc_source_o     = ctrl.pc_source;
  assign alu_op_o        = ctrl.alu_op;
  assign illegal_op_o    = illegal_q;
  assign instr_done_o    = done_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
//
// Purpose: drives directed and random instruction streams with random memory
// wait states and compares every cycle against a path-table reference model.
// Ports: none (top-level bench).

module tb_multicycle_control;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] opcode_i = 6'd0;
  logic       mem_ready_i = 1'b1;
  logic       pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o;
  logic       mem_write_o, reg_write_o, i_or_d_o, mem_to_reg_o;
  logic       reg_dst_o, alu_src_a_o, illegal_op_o, instr_done_o;
  logic [1:0] alu_src_b_o, pc_source_o, alu_op_o;
  logic [3:0] state_o;

  multicycle_control dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .opcode_i        (opcode_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .ir_write_o      (ir_write_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .reg_write_o     (reg_write_o),
    .i_or_d_o        (i_or_d_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_dst_o       (reg_dst_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .pc_source_o     (pc_source_o),
    .alu_op_o        (alu_op_o),
    .illegal_op_o    (illegal_op_o),
    .instr_done_o    (instr_done_o),
    .state_o         (state_o)
  );

  always #5 clk_i = ~clk_i;

  logic [15:0] obs_ctrl;
  assign obs_ctrl = {pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o,
                     mem_write_o, reg_write_o, i_or_d_o, mem_to_reg_o,
                     reg_dst_o, alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o};

  typedef struct {
    int st;
    bit rdy;
  } step_t;

  int n_total = 0;
  int n_pass  = 0;
  bit prev_done = 1'b0;
  bit prev_ill  = 1'b0;
  logic [5:0] legal_ops [6];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  // Control lines required in each state, straight from the per-state table
  function automatic logic [15:0] exp_ctrl(input int st, input bit rdy);
    logic pcw, pcc, irw, mr, mw, rw, iod, m2r, rd, sa;
    logic [1:0] sb, ps, ao;
    {pcw, pcc, irw, mr, mw, rw, iod, m2r, rd, sa, sb, ps, ao} = 16'h0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  sb = 2'b11;
      2,
      10: begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pcc = 1; end
      9:  begin pcw = 1; ps = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcc, irw, mr, mw, rw, iod, m2r, rd, sa, sb, ps, ao};
  endfunction

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_state"}, 16'(state_o), 16'd0);
    chk({tag, "_ctrl"}, obs_ctrl, 16'h0);
    chk({tag, "_done"}, 16'(instr_done_o), 16'd0);
    chk({tag, "_illegal"}, 16'(illegal_op_o), 16'd0);
  endtask

  // Runs one instruction. fw/mw are mem_ready-low cycles in FETCH and in the
  // data-memory state. Outside DECODE the opcode bus carries other_op (or
  // random junk) to show it is ignored. stop_after < 0 runs the whole path.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] other_op,
                           input bit rand_other, input int fw, input int mw,
                           input int stop_after);
    logic [23:0] p;
    int          n;
    bit          legal;
    step_t       seq[$];
    step_t       s;
    legal = 1'b1;
    case (op)
      6'b000000: begin p = 24'h000167; n = 4; end
      6'b100011: begin p = 24'h001234; n = 5; end
      6'b101011: begin p = 24'h000125; n = 4; end
      6'b000100: begin p = 24'h000018; n = 3; end
      6'b000010: begin p = 24'h000019; n = 3; end
      6'b001000: begin p = 24'h0001AB; n = 4; end
      default:   begin p = 24'h000001; n = 2; legal = 1'b0; end
    endcase
    for (int k = 0; k < n; k++) begin
      s.st = int'(p[4*(n-1-k) +: 4]);
      if (s.st == 0 || s.st == 3 || s.st == 5) begin
        for (int w = 0; w < ((s.st == 0) ? fw : mw); w++) begin
          s.rdy = 1'b0;
          seq.push_back(s);
        end
        s.rdy = 1'b1;
      end else begin
        s.rdy = 1'($urandom);
      end
      seq.push_back(s);
    end
    for (int i = 0; i < seq.size(); i++) begin
      if (stop_after >= 0 && i >= stop_after) break;
      @(negedge clk_i);
      mem_ready_i = seq[i].rdy;
      opcode_i = (seq[i].st == 1) ? op : (rand_other ? 6'($urandom) : other_op);
      #1;
      chk("state", 16'(state_o), 16'(seq[i].st));
      chk("ctrl", obs_ctrl, exp_ctrl(seq[i].st, seq[i].rdy));
      chk("instr_done", 16'(instr_done_o), 16'((i == 0) ? prev_done : 1'b0));
      chk("illegal_op", 16'(illegal_op_o), 16'((i == 0) ? prev_ill : 1'b0));
    end
    prev_done = legal;
    prev_ill  = !legal;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] op;
    legal_ops[0] = 6'b000000;
    legal_ops[1] = 6'b100011;
    legal_ops[2] = 6'b101011;
    legal_ops[3] = 6'b000100;
    legal_ops[4] = 6'b000010;
    legal_ops[5] = 6'b001000;

    // Reset with mem_ready high: FETCH decode must still be masked
    rst_i = 1'b1;
    mem_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    chk_all_quiet("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_ready_i = 1'b0;
    #1;
    chk("release_state", 16'(state_o), 16'd0);
    chk("release_ctrl", obs_ctrl, exp_ctrl(0, 1'b0));
    prev_done = 1'b0;
    prev_ill  = 1'b0;

    // Directed instruction walk
    run_instr(6'b000000, 6'd0, 1'b1, 0, 0, -1);   // R: 0,1,6,7
    run_instr(6'b100011, 6'd0, 1'b1, 0, 2, -1);   // LW: 0,1,2,3,3,3,4
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0, -1);   // BEQ: 0,1,8
    run_instr(6'b000010, 6'd0, 1'b1, 0, 0, -1);   // J: 0,1,9
    run_instr(6'b111111, 6'd0, 1'b1, 0, 0, -1);   // illegal: 0,1
    run_instr(6'b101011, 6'b000100, 1'b0, 0, 2, -1); // SW with BEQ on bus after DECODE
    run_instr(6'b001000, 6'd0, 1'b1, 1, 0, -1);   // ADDI with a fetch wait

    // Asynchronous reset while waiting in MEMREAD
    run_instr(6'b100011, 6'd0, 1'b1, 0, 3, 4);
    #2;
    rst_i = 1'b1;
    #1;
    chk_all_quiet("async_reset");
    @(negedge clk_i);
    #1;
    chk_all_quiet("reset_hold");
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_ready_i = 1'b0;
    #1;
    chk("rerelease_state", 16'(state_o), 16'd0);
    chk("rerelease_ctrl", obs_ctrl, exp_ctrl(0, 1'b0));
    prev_done = 1'b0;
    prev_ill  = 1'b0;

    // Random instruction stream with random wait states
    for (int t = 0; t < 60; t++) begin
      int idx;
      idx = int'($urandom_range(0, 6));
      if (idx < 6) begin
        op = legal_ops[idx];
      end else begin
        op = 6'($urandom);
        for (int j = 0; j < 6; j++) begin
          if (op == legal_ops[j]) op = 6'b111111;
        end
      end
      run_instr(op, 6'd0, 1'b1, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle ARM/MIPS-style datapath. It decodes the 6-bit instruction opcode and sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath strobe and mux select. It also produces the 2-bit `alu_op` that the ALU control stage consumes together with the funct field. Memory accesses use a ready handshake, so instruction and data memories may insert wait states.

## Interface
- No parameters. Opcodes, state codes and `alu_op` codes are fixed constants.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: instruction register bits [31:26]. Sampled only in DECODE.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `reg_write` out 1 each: strobes.
- `i_or_d`, `mem_to_reg`, `reg_dst`, `alu_src_a` out 1 each: mux selects.
- `alu_src_b` out 2: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `pc_source` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `alu_op` out 2: 00 add (LW/SW/PC/ADDI), 01 subtract (branch), 10 R-type (use funct).
- `illegal_op` out 1: registered one-cycle pulse on an unknown opcode.
- `instr_done` out 1: registered one-cycle pulse when an instruction retires.
- `state` out 4: current state, for debug.

## Operation
- **Opcodes:** R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- **States:** FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12–15 are unused and go to FETCH.
- **Outputs per state:** Moore outputs. Any signal not listed is 0.
  - FETCH: mem_read=1, alu_src_b=01. ir_write = pc_write = mem_ready.
  - DECODE: alu_src_b=11.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10.
  - MEMREAD: mem_read=1, i_or_d=1.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - MEMWRITE: mem_write=1, i_or_d=1.
  - EXECUTE: alu_src_a=1, alu_op=10.
  - ALUWB: reg_write=1, reg_dst=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_source=01, pc_write_cond=1.
  - JUMP: pc_write=1, pc_source=10.
  - ADDIWB: reg_write=1.
- **Transitions:**
  - FETCH→DECODE when mem_ready, otherwise hold.
  - DECODE: R→EXECUTE, LW/SW→MEMADR, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX. Any other opcode→FETCH with illegal_op pulsed.
  - MEMADR→MEMREAD (LW) or MEMWRITE (SW).
  - MEMREAD→MEMWB when mem_ready, otherwise hold.
  - MEMWRITE→FETCH when mem_ready, otherwise hold.
  - EXECUTE→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
- **Retire:** `instr_done` pulses the cycle after leaving MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, or MEMWRITE with mem_ready. It does not pulse for illegal opcodes.
- **Opcode sampling:** MEMADR reuses the opcode latched in DECODE, so a change on `opcode` after DECODE has no effect.

## Timing
- **Reset:** while `rst`=1, state=FETCH and every strobe is forced to 0: pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, illegal_op, instr_done. Mux selects and alu_op read 0. The first FETCH cycle is the first rising edge after `rst` falls.
- **Reset mid-instruction:** aborts immediately and asynchronously, with no partial writeback. Strobes drop in the same cycle that `rst` rises.
- **Zero-wait latency** (mem_ready held 1), FETCH to FETCH: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, illegal 2.
- **Wait states:** each low cycle of mem_ready adds one cycle to FETCH, MEMREAD or MEMWRITE. Outputs stay stable throughout the wait.
- **mem_ready outside memory states:** ignored.
- **alu_op:** valid in the same cycle as its state. The ALU control stage must settle within that cycle.

## Structure
- **Package `cpu_ctrl_pkg`:** opcode localparams, state encoding, `alu_op` codes (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE), and `alu_src_b`/`pc_source` select codes. The ALU control stage imports the same `alu_op` codes.
- **Sub-module `multicycle_control_decode`:** purely combinational, maps state and mem_ready to the datapath outputs. The top level holds the state register, next-state logic, latched opcode and pulse registers.

## Test plan
- Reset, release, mem_ready=1, opcode R-type: states 0,1,6,7,0. alu_op=10 only in state 6. reg_write=1, reg_dst=1 only in state 7. instr_done pulses once.
- LW with mem_ready low for 2 cycles in MEMREAD: states 0,1,2,3,3,3,4,0. mem_read and i_or_d stay 1 in state 3. mem_to_reg=1 in state 4.
- BEQ: states 0,1,8,0. alu_op=01, pc_write_cond=1, pc_source=01 in state 8. J: pc_write=1, pc_source=10 in state 9.
- Opcode 111111: states 0,1,0. illegal_op pulses 1 cycle. No reg_write, mem_write or instr_done.
- SW, then change opcode to BEQ during MEMADR: still enters MEMWRITE (5). mem_write=1 until mem_ready.
- Assert rst asynchronously in state 3: state=0 and mem_read=0 immediately. FETCH resumes on the first edge after release.
